apb_slave_mem: RTL
==================

# apb_slave_mem

APB4 completer (slave) that decodes transfers driven through the `apb_if` slave-side signals and services them from a word-addressed, byte-strobed local memory. It sits directly downstream of the APB bus: it consumes PADDR/PWRITE/PWDATA/PSTRB/PENABLE/PSEL and produces PREADY/PRDATA/PSLVERR. It serves as the DUT-side completer for the master agent and as the reference model for the slave agent. Wait states are configurable, and out-of-range or misaligned accesses return an error.

## Interface
- `DATA_W`, 32, data bus width; must be 32.
- `DEPTH`, 256, number of 32-bit words; must be a power of 2.
- `BASE_ADDR`, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH*4.
- `WAIT_CYCLES`, 2, number of PREADY-low access cycles per transfer (0..15).
- `PCLK` input 1: bus clock; all logic on rising edge.
- `PRESETn` input 1: asynchronous, active-low reset; one clock domain only.
- `PSEL` input 1: completer select.
- `PENABLE` input 1: access phase indicator.
- `PADDR` input 32: byte address.
- `PWRITE` input 1: 1 = write, 0 = read.
- `PWDATA` input 32: write data.
- `PSTRB` input 4: write byte-lane enables; ignored on reads.
- `PPROT` input 3: accepted and unused.
- `PRDATA` output 32: read data, registered.
- `PREADY` output 1: transfer completion, registered.
- `PSLVERR` output 1: error response, registered; valid only while PREADY=1.

## Operation
- Reset values: PREADY=0, PSLVERR=0, PRDATA=0, FSM state=IDLE, wait counter=0. Memory contents are not reset.
- FSM states are IDLE, WAIT and READY.
- **IDLE**
  - Setup phase is detected when PSEL=1 and PENABLE=0.
  - On detection, latch address, direction, data and strobe, and compute `err`.
  - `err` = (PADDR[1:0] != 0) OR (PADDR < BASE_ADDR) OR (word index = (PADDR-BASE_ADDR)>>2 >= DEPTH).
  - If WAIT_CYCLES=0: go to READY. Load PREADY<=1 and PSLVERR<=err. For a read, load PRDATA<=(err ? 0 : mem[idx]).
  - Otherwise: load cnt<=WAIT_CYCLES and go to WAIT.
- **WAIT**
  - cnt decrements on each cycle with PSEL&PENABLE.
  - When cnt==1: go to READY and load PREADY/PSLVERR/PRDATA as above.
- **READY**
  - PREADY is high for exactly one cycle.
  - At the closing edge, a write with err=0 updates only the byte lanes where PSTRB[i]=1.
  - Clear PREADY<=0 and PSLVERR<=0, then go to IDLE.
- An errored write leaves memory untouched. An errored read returns 0.
- PSEL deasserting in WAIT or READY is a protocol violation. Response: go to IDLE immediately, commit no write, clear PREADY.
- Back-to-back transfers: the next setup phase is accepted in IDLE on the cycle after READY. No idle cycle is required between transfers.
- PRDATA holds its last value outside READY. During write completion PRDATA is driven 0.

## Timing
- Zero-wait case: setup at edge N, PREADY=1 during cycle N+1, transfer completes at edge N+2.
- General case: transfer latency = 2 + WAIT_CYCLES cycles from the start of setup.
- Write data is visible to a read whose setup edge follows the write's completing edge. No bypass is needed.
- An async reset assertion at any point aborts the transfer, drops PREADY/PSLVERR within the same cycle, and discards any pending write.

## Configuration
- `APB_SLV_WAIT_EN` defined: the WAIT state and a 4-bit counter are compiled in, and WAIT_CYCLES is honoured.
- `APB_SLV_WAIT_EN` undefined: no counter and no WAIT state. Every transfer is zero-wait regardless of WAIT_CYCLES.

## Structure
- Package `apb_slv_pkg` holds:
  - the state enum `apb_slv_state_e` (IDLE, WAIT, READY);
  - localparams for the 32-bit address/data widths and 4-bit strobe width;
  - the function `apb_slv_addr_err(addr, base, depth)`, shared with the bench model.
- Sub-module `apb_slv_mem_array` is a DEPTH x 32 byte-enable RAM. It has a synchronous write port, a read port, and no reset.
- The top level contains the FSM, address decode, counter and output registers.

## Test plan
- Reset then write 0xDEADBEEF @0x10 with PSTRB=4'hF, read @0x10 -> PRDATA=0xDEADBEEF, PSLVERR=0, PREADY high 2 cycles after PENABLE rises (WAIT_CYCLES=2).
- Write 0x11223344 @0x20, then write 0xAABBCCDD with PSTRB=4'b0101, read @0x20 -> 0x11BB33DD.
- Read @0x402 (misaligned) and @0x400 (DEPTH=256, out of range) -> PSLVERR=1, PRDATA=0. A following read @0x0 returns its prior contents.
- Build without `APB_SLV_WAIT_EN`: 8 back-to-back writes then reads -> each PREADY on the first access cycle, all data correct.
- Assert PRESETn low while in WAIT during a write to @0x30 -> PREADY=0 immediately. A later read @0x30 returns the old value.
- Drop PSEL in WAIT -> FSM returns to IDLE and no write occurs. The next transfer completes normally.

Source files
------------

// File: rtl/apb_slv_pkg.sv
// apb_slv_pkg: shared types, widths and address-decode helper for apb_slave_mem.
// Contents:
//   APB_ADDR_W / APB_DATA_W / APB_STRB_W : bus widths (32 / 32 / 4)
//   apb_slv_state_e                      : completer FSM states
//   apb_slv_addr_err()                   : misaligned / below-base / past-end check
package apb_slv_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb_slv_state_e;

    // An access is in error when it is not word aligned, lies below the
    // window base, or its word index falls past the end of the memory.
    function automatic logic apb_slv_addr_err(
        input logic [APB_ADDR_W-1:0] addr,
        input logic [APB_ADDR_W-1:0] base,
        input int unsigned           depth
    );
        logic [APB_ADDR_W-1:0] offset;
        offset = addr - base;
        return (addr[1:0] != 2'b00) || (addr < base) || ((offset >> 2) >= depth);
    endfunction

endpackage

// File: rtl/apb_slv_mem_array.sv
// apb_slv_mem_array: DEPTH x 32 byte-enable RAM, no reset.
// Ports:
//   PCLK  : clock, write on rising edge
//   we    : write enable
//   strb  : byte-lane enables for the write
//   idx   : word index shared by the read and write ports
//   wdata : write data
//   rdata : combinational read of mem[idx]
module apb_slv_mem_array
    import apb_slv_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic                  PCLK,
    input  logic                  we,
    input  logic [APB_STRB_W-1:0] strb,
    input  logic [AW-1:0]         idx,
    input  logic [APB_DATA_W-1:0] wdata,
    output logic [APB_DATA_W-1:0] rdata
);

    logic [APB_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge PCLK) begin
        if (we) begin
            for (int b = 0; b < APB_STRB_W; b++) begin
                if (strb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB4 completer backed by a word-addressed byte-strobed memory.
// Optional build macro: APB_SLV_WAIT_EN -- when defined, WAIT_CYCLES access
// cycles with PREADY low are inserted per transfer; otherwise every transfer
// is zero-wait.
// Ports:
//   PCLK, PRESETn            : clock, async active-low reset
//   PSEL, PENABLE            : select / access phase
//   PADDR, PWRITE            : byte address, direction
//   PWDATA, PSTRB            : write data, write byte lanes
//   PPROT                    : accepted, unused
//   PRDATA, PREADY, PSLVERR  : registered response
//
// state | meaning
// IDLE  | waiting for a setup phase (PSEL=1, PENABLE=0)
// WAIT  | access phase, PREADY low, counting down wait cycles
// READY | PREADY high for one cycle; write commits on the closing edge
module apb_slave_mem
    import apb_slv_pkg::*;
#(
    parameter int                    DATA_W      = 32,
    parameter int                    DEPTH       = 256,
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned           WAIT_CYCLES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [APB_ADDR_W-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [DATA_W-1:0]     PWDATA,
    input  logic [APB_STRB_W-1:0] PSTRB,
    input  logic [2:0]            PPROT,
    output logic [DATA_W-1:0]     PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int AW = $clog2(DEPTH);

    apb_slv_state_e        state;
    logic [APB_ADDR_W-1:0] addr_q;
    logic                  write_q;
    logic                  err_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [APB_STRB_W-1:0] strb_q;
`ifdef APB_SLV_WAIT_EN
    logic [3:0]            cnt;
`else
    localparam int unsigned unused_wait_cycles = WAIT_CYCLES;
`endif

    logic                  setup;
    logic                  err_now;
    logic [APB_ADDR_W-1:0] addr_sel;
    logic                  err_sel;
    logic                  write_sel;
    logic [AW-1:0]         word_idx;
    logic [DATA_W-1:0]     rd_data;
    logic [DATA_W-1:0]     rsp_data;
    logic                  mem_we;
    logic                  unused_ok;

    assign setup   = PSEL && !PENABLE;
    assign err_now = apb_slv_addr_err(PADDR, BASE_ADDR, DEPTH);

    // In IDLE the response (zero-wait case) is built straight from the bus;
    // in WAIT/READY it comes from the values latched at setup.
    assign addr_sel  = (state == IDLE) ? PADDR   : addr_q;
    assign err_sel   = (state == IDLE) ? err_now : err_q;
    assign write_sel = (state == IDLE) ? PWRITE  : write_q;
    assign word_idx  = AW'((addr_sel - BASE_ADDR) >> 2);
    assign rsp_data  = (write_sel || err_sel) ? '0 : rd_data;

    // Commit only on a completing edge that still has PSEL; a dropped PSEL
    // aborts the transfer without touching memory.
    assign mem_we = (state == READY) && PSEL && write_q && !err_q;

    assign unused_ok = ^PPROT;

    apb_slv_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .PCLK  (PCLK),
        .we    (mem_we),
        .strb  (strb_q),
        .idx   (word_idx),
        .wdata (wdata_q),
        .rdata (rd_data)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= IDLE;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
`ifdef APB_SLV_WAIT_EN
            cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (setup) begin
                        addr_q  <= PADDR;
                        write_q <= PWRITE;
                        err_q   <= err_now;
                        wdata_q <= PWDATA;
                        strb_q  <= PSTRB;
`ifdef APB_SLV_WAIT_EN
                        if (WAIT_CYCLES == 0) begin
                            state   <= READY;
                            PREADY  <= 1'b1;
                            PSLVERR <= err_sel;
                            PRDATA  <= rsp_data;
                        end else begin
                            cnt   <= 4'(WAIT_CYCLES);
                            state <= WAIT;
                        end
`else
                        state   <= READY;
                        PREADY  <= 1'b1;
                        PSLVERR <= err_sel;
                        PRDATA  <= rsp_data;
`endif
                    end
                end
`ifdef APB_SLV_WAIT_EN
                WAIT: begin
                    if (!PSEL) begin
                        state <= IDLE;
                    end else if (PENABLE) begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state   <= READY;
                            PREADY  <= 1'b1;
                            PSLVERR <= err_sel;
                            PRDATA  <= rsp_data;
                        end
                    end
                end
`endif
                READY: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
